// File: rtl/rcu_pkg.sv
// Purpose: shared definitions for the reset request controller.
//   - rcu_state_e : sequencing FSM states
//   - CAUSE_*     : bit positions inside the cause_o flag vector
//   - CNT_W       : width of the debounce and sequencing counters
package rcu_pkg;

  localparam int CNT_W = 8;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_EXT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_WAIT
  } rcu_state_e;

endpackage

// File: rtl/rst_req_debounce.sv
// Purpose: brings the asynchronous external reset pin into clk_i through a
// two-flop synchronizer and qualifies it with a saturating debounce counter.
// Ports:
//   clk_i         : system clock
//   rst_i         : asynchronous active-high reset
//   ext_rst_req_i : raw external reset request pin (asynchronous level)
//   ext_req       : high while the pin has been high for DEBOUNCE_CYCLES
//                   consecutive synchronized cycles
module rst_req_debounce
  import rcu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ext_rst_req_i,
  output logic ext_req
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= ext_rst_req_i;
      sync2 <= sync1;
      // any low cycle restarts qualification; the count parks at its limit
      if (!sync2)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  assign ext_req = (deb_cnt == DEB_MAX);

endmodule

// File: rtl/rst_req_ctrl.sv
// Purpose: collects software, watchdog and external reset requests, performs
// a request/acknowledge handshake with the reset/clock unit, then drives a
// fixed-length system reset pulse. Records sticky cause and timeout flags.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   sw_rst_req_i  : software request, single-cycle pulse
//   wdt_rst_req_i : watchdog request, level
//   ext_rst_req_i : external pin request, asynchronous level
//   rst_ack_i     : acknowledge from the reset/clock unit, level
//   cause_clr_i   : pulse clearing cause_o and timeout_o
//   rst_req_o     : request to the reset/clock unit
//   rst_o         : system reset pulse, HOLD_CYCLES long
//   busy_o        : sequence in progress
//   cause_o       : sticky {ext, wdt, sw} cause flags
//   timeout_o     : sticky acknowledge-timeout flag
module rst_req_ctrl
  import rcu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT     = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_rst_req_i,
  input  logic       ext_rst_req_i,
  input  logic       rst_ack_i,
  input  logic       cause_clr_i,
  output logic       rst_req_o,
  output logic       rst_o,
  output logic       busy_o,
  output logic [2:0] cause_o,
  output logic       timeout_o
);

  // Counters are loaded with N-1 and the phase ends on the cycle they read 0,
  // so each phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  rcu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_req;
  logic             tmo_evt;
  logic [2:0]       req_vec;

  rst_req_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ext_rst_req_i(ext_rst_req_i),
    .ext_req      (ext_req)
  );

  always_comb begin
    req_vec            = '0;
    req_vec[CAUSE_SW]  = sw_rst_req_i;
    req_vec[CAUSE_WDT] = wdt_rst_req_i;
    req_vec[CAUSE_EXT] = ext_req;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_REQ;
          cnt_d   = ACK_LOAD;
        end
      end
      ST_REQ: begin
        if (rst_ack_i) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          tmo_evt = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0)
          state_d = ST_WAIT;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      ST_WAIT: begin
        // a software pulse is deliberately ignored here; only level
        // requests and a lingering acknowledge keep the sequence parked
        if (!wdt_rst_req_i && !ext_req && !rst_ack_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rst_req_o <= 1'b0;
      rst_o     <= 1'b0;
      busy_o    <= 1'b0;
      cause_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_req_o <= (state_d == ST_REQ);
      rst_o     <= (state_d == ST_HOLD);
      busy_o    <= (state_d != ST_IDLE);
      // new requests are OR-ed after the clear so a coincident set wins
      cause_o   <= (cause_clr_i ? 3'b000 : cause_o) | req_vec;
      timeout_o <= (cause_clr_i ? 1'b0 : timeout_o) | tmo_evt;
    end
  end

endmodule

// File: tb/tb_rst_req_ctrl.sv
module tb_rst_req_ctrl;

  localparam int HOLD = 16;
  localparam int DEB  = 8;
  localparam int TMO  = 64;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_HOLD = 2;
  localparam int P_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw, wdt, ext, ack, clr;
  logic       rst_req_o, rst_o, busy_o, timeout_o;
  logic [2:0] cause_o;

  always #5 clk = ~clk;

  rst_req_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sw_rst_req_i (sw),
    .wdt_rst_req_i(wdt),
    .ext_rst_req_i(ext),
    .rst_ack_i    (ack),
    .cause_clr_i  (clr),
    .rst_req_o    (rst_req_o),
    .rst_o        (rst_o),
    .busy_o       (busy_o),
    .cause_o      (cause_o),
    .timeout_o    (timeout_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // reference model: phase plus elapsed-cycle counts, ext pin history window
  int       m_phase;
  int       m_in_req, m_in_hold;
  bit [2:0] m_cause;
  bit       m_tmo;
  bit       ext_hist[$];

  bit ack_auto = 0;
  int n_req_cyc, n_hold_cyc, n_busy_cyc, n_rst_rise;
  bit prev_rst_o;

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_in_req  = 0;
    m_in_hold = 0;
    m_cause   = '0;
    m_tmo     = 0;
    ext_hist.delete();
    for (int i = 0; i < DEB + 2; i++) ext_hist.push_back(1'b0);
  endtask

  // pin accepted when it was high for DEB consecutive cycles, seen through
  // two synchronizer stages plus one counter stage
  function automatic bit m_ext_req();
    for (int k = 2; k < DEB + 2; k++)
      if (!ext_hist[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit er;
    bit tev;
    er  = m_ext_req();
    tev = 0;
    case (m_phase)
      P_IDLE: if (sw || wdt || er) begin m_phase = P_REQ; m_in_req = 0; end
      P_REQ: begin
        m_in_req++;
        if (ack) begin
          m_phase = P_HOLD; m_in_hold = 0;
        end else if (m_in_req == TMO) begin
          tev = 1; m_phase = P_HOLD; m_in_hold = 0;
        end
      end
      P_HOLD: begin
        m_in_hold++;
        if (m_in_hold == HOLD) m_phase = P_WAIT;
      end
      default: if (!wdt && !er && !ack) m_phase = P_IDLE;
    endcase
    m_cause = (clr ? 3'b000 : m_cause) | {er, wdt, sw};
    m_tmo   = (clr ? 1'b0 : m_tmo) | tev;
    ext_hist.push_front(ext);
    void'(ext_hist.pop_back());
  endtask

  task automatic clear_counts();
    n_req_cyc  = 0;
    n_hold_cyc = 0;
    n_busy_cyc = 0;
    n_rst_rise = 0;
  endtask

  // one clock: model consumes the inputs held this cycle, DUT samples them,
  // then outputs are compared 1 time unit after the edge
  task automatic tick();
    if (ack_auto) ack = rst_req_o;
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    sw  = 0;
    clr = 0;
    chk("rst_req_o", rst_req_o, m_phase == P_REQ);
    chk("rst_o",     rst_o,     m_phase == P_HOLD);
    chk("busy_o",    busy_o,    m_phase != P_IDLE);
    chk("cause_o",   cause_o,   m_cause);
    chk("timeout_o", timeout_o, m_tmo);
    if (rst_req_o) n_req_cyc++;
    if (rst_o)     n_hold_cyc++;
    if (busy_o)    n_busy_cyc++;
    if (rst_o && !prev_rst_o) n_rst_rise++;
    prev_rst_o = rst_o;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   rst_req_o, 0);
    chk({tag, "_rst"},   rst_o,     0);
    chk({tag, "_busy"},  busy_o,    0);
    chk({tag, "_cause"}, cause_o,   0);
    chk({tag, "_tmo"},   timeout_o, 0);
  endtask

  task automatic async_reset(input string tag);
    rst = 1;
    #2;
    check_reset_outputs(tag);
    model_reset();
    sw = 0; clr = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_rst_o(input string tag);
    int k;
    k = 0;
    while (!rst_o && k < 200) begin tick(); k++; end
    chk(tag, rst_o, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy_o && k < 300) begin tick(); k++; end
    chk(tag, busy_o, 0);
  endtask

  initial begin
    int k;
    int ack_mode;
    rst = 1; sw = 0; wdt = 0; ext = 0; ack = 0; clr = 0;
    prev_rst_o = 0;
    model_reset();
    #2;
    check_reset_outputs("por");
    repeat (3) tick();
    rst = 0;
    repeat (5) tick();

    // software pulse, ack rising on the 4th request cycle
    clear_counts();
    sw = 1;
    tick();
    chk("s1_first_req", rst_req_o, 1);
    repeat (3) tick();
    ack = 1;
    tick();
    ack = 0;
    repeat (25) tick();
    chk("s1_req_cycles",  n_req_cyc,  4);
    chk("s1_hold_cycles", n_hold_cyc, HOLD);
    chk("s1_busy_cycles", n_busy_cyc, 4 + HOLD + 1);
    chk("s1_cause",       cause_o,    3'b001);

    // external pin: short glitches ignored, held level accepted
    clr = 1;
    tick();
    clear_counts();
    repeat (3) begin
      ext = 1; repeat (5) tick();
      ext = 0; repeat (5) tick();
    end
    chk("s2_glitch_req", n_req_cyc, 0);
    ext = 1;
    k = 0;
    while (!rst_req_o && k < 50) begin tick(); k++; end
    chk("s2_latency", k, DEB + 3);
    ack_auto = 1;
    repeat (40) tick();
    chk("s2_held_busy", busy_o, 1);
    ext = 0;
    wait_idle("s2_idle");
    ack_auto = 0; ack = 0;
    chk("s2_cause", cause_o, 3'b100);

    // acknowledge never arrives
    clr = 1;
    tick();
    clear_counts();
    sw = 1;
    repeat (100) tick();
    chk("s3_req_cycles",  n_req_cyc,  TMO);
    chk("s3_hold_cycles", n_hold_cyc, HOLD);
    chk("s3_timeout",     timeout_o,  1);
    chk("s3_cause",       cause_o,    3'b001);

    // watchdog held through the sequence, sw pulse during HOLD
    clr = 1;
    tick();
    clear_counts();
    wdt = 1;
    ack_auto = 1;
    wait_rst_o("s4_reach_hold");
    repeat (3) tick();
    sw = 1;
    tick();
    repeat (40) tick();
    chk("s4_parked", busy_o, 1);
    wdt = 0;
    repeat (3) tick();
    chk("s4_idle",   busy_o,     0);
    chk("s4_cause",  cause_o,    3'b011);
    chk("s4_pulses", n_rst_rise, 1);

    // clear coincident with watchdog request
    wdt = 1; clr = 1;
    tick();
    chk("s6_cause", cause_o, 3'b010);
    wdt = 0;
    wait_idle("s6_idle");

    // reset asserted mid-HOLD
    sw = 1;
    wait_rst_o("s5_reach_hold");
    repeat (4) tick();
    async_reset("s5_async");
    ack_auto = 0; ack = 0;
    clear_counts();
    repeat (30) tick();
    chk("s5_no_residual", n_hold_cyc, 0);

    // randomized traffic against the model
    ack_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ack_mode = $urandom_range(0, 2);
      ack_auto = (ack_mode == 1);
      if (ack_mode == 0) ack = ($urandom_range(0, 3) == 0);
      if (ack_mode == 2) ack = 0;
      sw  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 59) == 0) wdt = ~wdt;
      if ($urandom_range(0, 15) == 0) ext = ~ext;
      if ($urandom_range(0, 799) == 0) async_reset("rnd_async");
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
